// File: rtl/sa_reduce_pkg.sv
// Shared defaults and sizing helpers for the systolic-array reduction tree.
package sa_reduce_pkg;

  localparam int unsigned DEF_NUM_CH = 8;
  localparam int unsigned DEF_IN_W   = 8;
  localparam int unsigned DEF_ACC_W  = 16;
  localparam int unsigned DEF_BEAT_W = 8;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Number of registered adder levels (L).
  function automatic int unsigned tree_levels(input int unsigned num_ch);
    return clog2(num_ch);
  endfunction

  // Channel count padded to the next power of two (P).
  function automatic int unsigned tree_width(input int unsigned num_ch);
    return 32'd1 << clog2(num_ch);
  endfunction

  // Width of the final tree sum (SUM_W = IN_W + L).
  function automatic int unsigned sum_width(input int unsigned in_w, input int unsigned num_ch);
    return in_w + clog2(num_ch);
  endfunction

endpackage

// File: rtl/sa_add_stage.sv
// One registered level of the reduction tree: pairwise sums, one bit wider.
module sa_add_stage
  import sa_reduce_pkg::*;
#(
  parameter int unsigned PAIRS = 4,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   adv,
  input  logic [2*PAIRS*W-1:0]   operands,
  input  logic                   operands_valid,
  output logic [PAIRS*(W+1)-1:0] sums,
  output logic                   sums_valid
);

  // Capture pairwise sums and the valid bit; hold everything (bubbles too) on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sums       <= '0;
      sums_valid <= 1'b0;
    end else if (adv) begin
      sums_valid <= operands_valid;
      for (int unsigned j = 0; j < PAIRS; j++) begin
        sums[j*(W+1) +: (W+1)] <= (W+1)'(operands[(2*j)*W +: W])
                                + (W+1)'(operands[(2*j+1)*W +: W]);
      end
    end
  end

endmodule

// File: rtl/sa_reduce_tree.sv
// Masked, pipelined channel reduction with multi-beat accumulation.
// Optional build macro SA_REDUCE_SAT_EN: accumulator clamps and reports out_sat.
module sa_reduce_tree
  import sa_reduce_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned BEAT_W = DEF_BEAT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CH*IN_W-1:0] in_data,
  input  logic [NUM_CH-1:0]      in_mask,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic [BEAT_W-1:0]      out_beats,
  output logic                   out_sat
);

  localparam int unsigned P     = tree_width(NUM_CH);
  localparam int unsigned L     = tree_levels(NUM_CH);
  localparam int unsigned SUM_W = sum_width(IN_W, NUM_CH);

  logic              adv;
  logic [P*IN_W-1:0] masked;
  logic [L-1:0]      last_pipe;
  logic [SUM_W-1:0]  tree_sum;
  logic              tree_valid;
  logic              tree_last;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Zero unselected channels and the power-of-two padding lanes.
  always_comb begin
    masked = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      masked[k*IN_W +: IN_W] = in_mask[k] ? in_data[k*IN_W +: IN_W] : '0;
    end
  end

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int unsigned W     = IN_W + i;
    localparam int unsigned PAIRS = P >> (i + 1);
    logic [2*PAIRS*W-1:0]   operands;
    logic                   operands_valid;
    logic [PAIRS*(W+1)-1:0] sums;
    logic                   sums_valid;

    if (i == 0) begin : g_first
      assign operands       = masked;
      assign operands_valid = in_valid && adv;
    end else begin : g_next
      assign operands       = g_lvl[i-1].sums;
      assign operands_valid = g_lvl[i-1].sums_valid;
    end

    sa_add_stage #(.PAIRS(PAIRS), .W(W)) u_stage (
      .clk           (clk),
      .reset         (reset),
      .adv           (adv),
      .operands      (operands),
      .operands_valid(operands_valid),
      .sums          (sums),
      .sums_valid    (sums_valid)
    );
  end

  assign tree_sum   = g_lvl[L-1].sums;
  assign tree_valid = g_lvl[L-1].sums_valid;
  assign tree_last  = last_pipe[L-1];

  // Carry the group delimiter alongside the tree levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pipe <= '0;
    end else if (adv) begin
      last_pipe[0] <= in_last;
      for (int unsigned i = 1; i < L; i++) last_pipe[i] <= last_pipe[i-1];
    end
  end

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [BEAT_W-1:0] cnt;
  logic [BEAT_W-1:0] cnt_next;
  logic              sat;
  logic              sat_next;
  logic              overflow;

`ifdef SA_REDUCE_SAT_EN
  logic [ACC_W:0] acc_sum;

  // Clamp the running sum at full scale and flag the overflow.
  always_comb begin
    acc_sum  = {1'b0, acc} + (ACC_W+1)'(tree_sum);
    overflow = acc_sum[ACC_W];
    acc_next = overflow ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  // Running sum wraps modulo 2^ACC_W; no saturation is ever reported.
  always_comb begin
    overflow = 1'b0;
    acc_next = acc + ACC_W'(tree_sum);
  end
`endif

  assign sat_next = sat | overflow;
  assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;

  // Accumulate beats; on the last beat publish the group and clear for the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      if (tree_valid && tree_last) begin
        out_data  <= acc_next;
        out_beats <= cnt_next;
        out_sat   <= sat_next;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        sat       <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (tree_valid) begin
          acc <= acc_next;
          cnt <= cnt_next;
          sat <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_reduce_tree.sv
// Randomized and directed bench for sa_reduce_tree (NUM_CH=8, IN_W=8, ACC_W=16).
// Honours SA_REDUCE_SAT_EN to select clamping or wrapping expectations.
module tb_sa_reduce_tree;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned BEAT_W = 8;
  localparam int          LAT    = 3;
  localparam longint      ACC_MAX  = (64'd1 << ACC_W) - 1;
  localparam longint      BEAT_MAX = (64'd1 << BEAT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_CH*IN_W-1:0] in_data;
  logic [NUM_CH-1:0]      in_mask;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_data;
  logic [BEAT_W-1:0]      out_beats;
  logic                   out_sat;

  sa_reduce_tree #(.NUM_CH(NUM_CH), .IN_W(IN_W), .ACC_W(ACC_W), .BEAT_W(BEAT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_beats(out_beats),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint beats;
    longint sat;
  } res_t;

  res_t   exp_q[$];
  res_t   mon_r;
  int     n_cmp = 0;
  int     n_err = 0;
  longint macc = 0;
  longint mcnt = 0;
  longint msat = 0;
  longint last_data = -1;
  longint last_beats = -1;
  longint last_sat = -1;
  bit     saw_stall = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint masked_sum(input logic [NUM_CH*IN_W-1:0] d,
                                        input logic [NUM_CH-1:0] m);
    longint s = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (m[k]) s += longint'(d[k*IN_W +: IN_W]);
    return s;
  endfunction

  // Reference model and scoreboard, sampled mid-cycle where all signals are settled.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      macc = 0;
      mcnt = 0;
      msat = 0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          mon_r = exp_q.pop_front();
          check("out_data", longint'(out_data), mon_r.data);
          check("out_beats", longint'(out_beats), mon_r.beats);
          check("out_sat", longint'(out_sat), mon_r.sat);
          last_data  = longint'(out_data);
          last_beats = longint'(out_beats);
          last_sat   = longint'(out_sat);
        end
      end
      if (in_valid && in_ready) begin
        macc += masked_sum(in_data, in_mask);
`ifdef SA_REDUCE_SAT_EN
        if (macc > ACC_MAX) begin
          macc = ACC_MAX;
          msat = 1;
        end
`else
        macc = macc % (ACC_MAX + 1);
`endif
        mcnt = (mcnt == BEAT_MAX) ? BEAT_MAX : mcnt + 1;
        if (in_last) begin
          exp_q.push_back('{macc, mcnt, msat});
          macc = 0;
          mcnt = 0;
          msat = 0;
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] m, input logic l);
    int w;
    w = 0;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (w >= 100) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    check("drain", longint'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] d;
    int cyc;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_beats", longint'(out_beats), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    @(posedge clk);
    #1;

    // Full-scale single beat and its latency
    send_beat({8{8'hFF}}, 8'hFF, 1'b1);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("latency", cyc, LAT);
    drain();
    check("full_data", last_data, 2040);
    check("full_beats", last_beats, 1);

    // Channel k = k+1, only channels 0 and 2 selected
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(k + 1);
    send_beat(d, 8'b0000_0101, 1'b1);
    drain();
    check("mask_data", last_data, 4);

    // Three-beat group
    send_beat({8{8'hFF}}, 8'hFF, 1'b0);
    send_beat({8{8'hFF}}, 8'hFF, 1'b0);
    repeat (6) @(negedge clk);
    check("no_early_out", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    send_beat({8{8'hFF}}, 8'hFF, 1'b1);
    drain();
    check("grp3_data", last_data, 6120);
    check("grp3_beats", last_beats, 3);

    // Downstream stall while streaming single-beat groups
    fork
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) send_beat({$urandom, $urandom}, 8'($urandom), 1'b1);
      end
    join
    drain();
    check("stall_seen", longint'(saw_stall), 1);

    // Reset in the middle of a group
    send_beat({8{8'hFF}}, 8'hFF, 1'b0);
    send_beat({8{8'hFF}}, 8'hFF, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send_beat({8{8'h01}}, 8'hFF, 1'b1);
    drain();
    check("rst_mid_data", last_data, 8);
    check("rst_mid_beats", last_beats, 1);

    // Beat counter saturation with all-zero masks
    for (int i = 0; i < 260; i++) send_beat({$urandom, $urandom}, 8'h00, i == 259);
    drain();
    check("cnt_sat_beats", last_beats, 255);
    check("cnt_sat_data", last_data, 0);

    // Accumulator overflow: 33 x 2040 = 67320
    for (int i = 0; i < 33; i++) send_beat({8{8'hFF}}, 8'hFF, i == 32);
    drain();
`ifdef SA_REDUCE_SAT_EN
    check("ovf_data", last_data, 65535);
    check("ovf_sat", last_sat, 1);
`else
    check("ovf_data", last_data, 1784);
    check("ovf_sat", last_sat, 0);
`endif

    // Random traffic with random backpressure and one mid-stream reset
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      reset    = (i == 300);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       in_mask = 8'h00;
        1:       in_mask = 8'hFF;
        default: in_mask = 8'($urandom);
      endcase
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
